// File: rtl/sym_tap_reader.sv
// sym_tap_reader: circular sample buffer swept in symmetric pairs, emitting one pre-added pair per beat.
// Optional feature: define SYM_TAP_READER_ANTISYM_EN to add the antisym input (pair difference a - b).
module sym_tap_reader #(
   parameter int DATA_WIDTH = 16,
   parameter int TAPS       = 32,
   parameter int DEPTH_LOG2 = 6
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic signed [DATA_WIDTH-1:0] s_data,
   input  logic                         s_valid,
   output logic                         s_ready,
`ifdef SYM_TAP_READER_ANTISYM_EN
   input  logic                         antisym,
`endif
   output logic signed [DATA_WIDTH:0]   m_preadd,
   output logic [$clog2(TAPS)-1:0]      m_coef_idx,
   output logic                         m_last,
   output logic                         m_valid,
   input  logic                         m_ready
);

   localparam int AW    = DEPTH_LOG2;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int KW    = $clog2(TAPS);
   localparam int PAIRS = (TAPS + 1) / 2;
   localparam bit ODD   = (TAPS % 2) == 1;

   localparam logic [KW-1:0] K_LAST   = KW'(PAIRS - 1);
   localparam logic [KW-1:0] K_CENTRE = KW'((TAPS - 1) / 2);
   localparam logic [AW-1:0] SPAN     = AW'(TAPS - 1);
   localparam logic [AW-1:0] A_LAST   = AW'(DEPTH - 1);

   typedef enum logic [1:0] {CLEAR, IDLE, SWEEP, DRAIN} state_t;

   typedef struct packed {
      logic signed [DATA_WIDTH:0] preadd;
      logic [KW-1:0]              idx;
      logic                       last;
   } beat_t;

   state_t                  state, state_nxt;
   logic [AW-1:0]           clr_cnt;
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           newest;
   logic [KW-1:0]           k;
   logic                    accept;
   logic                    issue;
   logic                    drain_done;
   logic [2:0]              load;

   logic signed [DATA_WIDTH-1:0] mem [DEPTH];
   logic                         mem_we;
   logic [AW-1:0]                mem_waddr;
   logic signed [DATA_WIDTH-1:0] mem_wdata;
   logic [AW-1:0]                addr_a, addr_b;
   logic signed [DATA_WIDTH-1:0] rd_a, rd_b;
   logic                         rd_vld;
   logic [KW-1:0]                rd_idx;
   logic                         rd_last;

   logic signed [DATA_WIDTH:0]   a_ext, b_ext, preadd;
   logic                         centre;
   beat_t                        push_beat;

   beat_t      fifo [2];
   logic       fifo_wr, fifo_rd;
   logic [1:0] fifo_cnt;
   logic       push, pop;

`ifdef SYM_TAP_READER_ANTISYM_EN
   logic antisym_q;
`endif

   assign accept = s_valid && s_ready;
   assign push   = rd_vld;
   assign pop    = (fifo_cnt != 2'd0) && m_ready;

   // Slots already committed (held beats plus the read in flight), net of the beat leaving this cycle.
   assign load       = 3'(fifo_cnt) + 3'(rd_vld) - 3'(pop);
   assign issue      = (state == SWEEP) && (load < 3'd2);
   assign drain_done = (load == 3'd0);

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      case (state)
         CLEAR: if (clr_cnt == A_LAST) state_nxt = IDLE;
         IDLE: begin
            s_ready = 1'b1;
            if (s_valid) state_nxt = SWEEP;
         end
         SWEEP: if (issue && (k == K_LAST)) state_nxt = DRAIN;
         DRAIN: if (drain_done) state_nxt = IDLE;
         default: state_nxt = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         wr_ptr  <= '0;
         newest  <= '0;
         k       <= '0;
         rd_vld  <= 1'b0;
         rd_idx  <= '0;
         rd_last <= 1'b0;
`ifdef SYM_TAP_READER_ANTISYM_EN
         antisym_q <= 1'b0;
`endif
      end else begin
         state  <= state_nxt;
         rd_vld <= issue;
         if (state == CLEAR) clr_cnt <= clr_cnt + AW'(1);
         if (accept) begin
            newest <= wr_ptr;
            wr_ptr <= wr_ptr + AW'(1);
            k      <= '0;
`ifdef SYM_TAP_READER_ANTISYM_EN
            antisym_q <= antisym;
`endif
         end else if (issue) begin
            k <= k + KW'(1);
         end
         if (issue) begin
            rd_idx  <= k;
            rd_last <= (k == K_LAST);
         end
      end
   end

   always_comb begin
      mem_we    = (state == CLEAR) || accept;
      mem_waddr = (state == CLEAR) ? clr_cnt : wr_ptr;
      mem_wdata = (state == CLEAR) ? '0 : s_data;
      addr_a    = newest - AW'(k);
      addr_b    = newest - SPAN + AW'(k);
   end

   // NOTE: the sample RAM has no reset; the CLEAR pass zeroes it so it still maps onto block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      rd_a <= mem[addr_a];
      rd_b <= mem[addr_b];
   end

   always_comb begin
      a_ext  = {rd_a[DATA_WIDTH-1], rd_a};
      b_ext  = {rd_b[DATA_WIDTH-1], rd_b};
      centre = ODD && (rd_idx == K_CENTRE);
      if (centre) b_ext = '0;
      preadd = a_ext + b_ext;
`ifdef SYM_TAP_READER_ANTISYM_EN
      if (antisym_q) preadd = centre ? '0 : (a_ext - b_ext);
`endif
      push_beat = '{preadd: preadd, idx: rd_idx, last: rd_last};
   end

   // Two-entry output FIFO; issue gating keeps it from ever being pushed while full.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fifo[0]  <= '0;
         fifo[1]  <= '0;
         fifo_wr  <= 1'b0;
         fifo_rd  <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         if (push) begin
            fifo[fifo_wr] <= push_beat;
            fifo_wr       <= ~fifo_wr;
         end
         if (pop) fifo_rd <= ~fifo_rd;
         fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
      end
   end

   assign m_valid    = (fifo_cnt != 2'd0);
   assign m_preadd   = fifo[fifo_rd].preadd;
   assign m_coef_idx = fifo[fifo_rd].idx;
   assign m_last     = fifo[fifo_rd].last;

endmodule

// File: tb/tb_sym_tap_reader.sv
// Directed bench for sym_tap_reader: two instances (TAPS=4 and TAPS=5, both with an 8-deep buffer).
// Define SYM_TAP_READER_ANTISYM_EN to also exercise the antisym input.
module tb_sym_tap_reader;

   localparam int DW = 16;

   typedef struct {
      logic signed [DW:0] p;
      int                 idx;
      logic               last;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst_n;
   logic                 s_valid;
   logic                 m_ready;
   logic                 sel;
   logic                 antisym;
   logic signed [DW-1:0] s_data;

   logic               rdy_a, mv_a, last_a;
   logic signed [DW:0] p_a;
   logic [1:0]         idx_a;
   logic               rdy_b, mv_b, last_b;
   logic signed [DW:0] p_b;
   logic [2:0]         idx_b;

   logic               o_rdy, o_mv, o_last;
   logic signed [DW:0] o_p;
   int                 o_idx;

   int errors = 0;
   int checks = 0;
   beat_t got[$];
   logic signed [DW-1:0] hist[$];

   sym_tap_reader #(.DATA_WIDTH(DW), .TAPS(4), .DEPTH_LOG2(3)) dut_a (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid && !sel), .s_ready(rdy_a),
`ifdef SYM_TAP_READER_ANTISYM_EN
      .antisym(antisym),
`endif
      .m_preadd(p_a), .m_coef_idx(idx_a), .m_last(last_a), .m_valid(mv_a), .m_ready(m_ready)
   );

   sym_tap_reader #(.DATA_WIDTH(DW), .TAPS(5), .DEPTH_LOG2(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid && sel), .s_ready(rdy_b),
`ifdef SYM_TAP_READER_ANTISYM_EN
      .antisym(antisym),
`endif
      .m_preadd(p_b), .m_coef_idx(idx_b), .m_last(last_b), .m_valid(mv_b), .m_ready(m_ready)
   );

   always_comb begin
      if (sel) begin
         o_rdy = rdy_b; o_mv = mv_b; o_p = p_b; o_idx = int'(idx_b); o_last = last_b;
      end else begin
         o_rdy = rdy_a; o_mv = mv_a; o_p = p_a; o_idx = int'(idx_a); o_last = last_a;
      end
   end

   function automatic logic signed [DW:0] hx(input int j);
      logic signed [DW:0] v;
      v = '0;
      if (j < hist.size()) v = hist[j];
      return v;
   endfunction

   // Reference beat k of the current sweep, from the accepted-sample history (newest first).
   function automatic beat_t model_beat(input int k, input int taps);
      beat_t b;
      logic signed [DW:0] a, c;
      a = hx(k);
      c = ((taps % 2 == 1) && (k == (taps - 1) / 2)) ? '0 : hx(taps - 1 - k);
      b.p    = a + c;
      b.idx  = k;
      b.last = (k == (taps + 1) / 2 - 1);
      return b;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      s_valid = 1'b0;
      rst_n   = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      hist.delete();
   endtask

   task automatic send(input logic signed [DW-1:0] d);
      int n;
      n = 0;
      @(negedge clk);
      while (!o_rdy && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (o_rdy !== 1'b1) begin
         errors++;
         $display("FAIL send_ready: s_ready=%b after %0d cycles, required 1", o_rdy, n);
      end else begin
         s_data  = d;
         s_valid = 1'b1;
         @(posedge clk);
         #1 s_valid = 1'b0;
         hist.push_front(d);
      end
   endtask

   // Collects n beats; while stalled, the presented beat must not change.
   task automatic collect(input int n, input bit rnd);
      int    cyc;
      bit    stalled;
      beat_t cur, prev;
      cyc = 0;
      stalled = 1'b0;
      prev = '{p: '0, idx: 0, last: 1'b0};
      got.delete();
      while (got.size() < n && cyc < 500) begin
         @(negedge clk);
         cyc++;
         cur = '{p: o_p, idx: o_idx, last: o_last};
         if (stalled) begin
            checks++;
            if (o_mv !== 1'b1 || int'(cur.p) != int'(prev.p) || cur.idx != prev.idx || cur.last !== prev.last) begin
               errors++;
               $display("FAIL stall_hold: valid=%b preadd=%0d idx=%0d last=%b, required 1 %0d %0d %b",
                        o_mv, cur.p, cur.idx, cur.last, prev.p, prev.idx, prev.last);
            end
         end
         m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         prev    = cur;
         stalled = o_mv && !m_ready;
         if (o_mv && m_ready) got.push_back(cur);
      end
      m_ready = 1'b1;
      checks++;
      if (got.size() != n) begin
         errors++;
         $display("FAIL collect_count: got %0d beats, required %0d", got.size(), n);
         while (got.size() < n) got.push_back('{p: '0, idx: -1, last: 1'bx});
      end
   endtask

   task automatic test_reset();
      int n;
      sel = 1'b0;
      s_data = 16'sd9;
      s_valid = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (o_rdy !== 1'b0 || o_mv !== 1'b0 || o_p !== '0 || o_idx != 0 || o_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: s_ready=%b m_valid=%b preadd=%0d idx=%0d last=%b, required all 0",
                  o_rdy, o_mv, o_p, o_idx, o_last);
      end
      rst_n = 1'b1;
      n = 0;
      while (!o_rdy && n < 100) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != 8) begin
         errors++;
         $display("FAIL clear_length: s_ready low for %0d cycles, required 8", n);
      end
      @(posedge clk);
      #1 s_valid = 1'b0;
      hist.delete();
      hist.push_front(16'sd9);
      collect(2, 1'b0);
      checks++;
      if (int'(got[0].p) != 9 || got[0].idx != 0 || got[0].last !== 1'b0 ||
          int'(got[1].p) != 0 || got[1].idx != 1 || got[1].last !== 1'b1) begin
         errors++;
         $display("FAIL first_after_clear: beats (%0d,%0d,%b) (%0d,%0d,%b), required (9,0,0) (0,1,1)",
                  got[0].p, got[0].idx, got[0].last, got[1].p, got[1].idx, got[1].last);
      end
   endtask

   task automatic test_taps4();
      int exp0[4] = '{1, 2, 3, 5};
      int exp1[4] = '{0, 1, 3, 5};
      sel = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send(DW'(i + 1));
         collect(2, 1'b0);
         checks++;
         if (int'(got[0].p) != exp0[i] || got[0].idx != 0 || got[0].last !== 1'b0 ||
             int'(got[1].p) != exp1[i] || got[1].idx != 1 || got[1].last !== 1'b1) begin
            errors++;
            $display("FAIL taps4_sample%0d: beats (%0d,%0d,%b) (%0d,%0d,%b), required (%0d,0,0) (%0d,1,1)",
                     i + 1, got[0].p, got[0].idx, got[0].last, got[1].p, got[1].idx, got[1].last,
                     exp0[i], exp1[i]);
         end
      end
   endtask

   task automatic test_taps5_centre();
      int exp_p[3] = '{6, 6, 3};
      sel = 1'b1;
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         send(DW'(i));
         collect(3, 1'b0);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (int'(got[k].p) != exp_p[k] || got[k].idx != k || got[k].last !== (k == 2)) begin
            errors++;
            $display("FAIL taps5_beat%0d: (%0d,%0d,%b), required (%0d,%0d,%b)",
                     k, got[k].p, got[k].idx, got[k].last, exp_p[k], k, (k == 2));
         end
      end
   endtask

   task automatic test_sign_ext();
      sel = 1'b0;
      do_reset();
      repeat (4) begin
         send(-16'sd32768);
         collect(2, 1'b0);
      end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (int'(got[k].p) != -65536) begin
            errors++;
            $display("FAIL sign_neg_beat%0d: preadd=%0d, required -65536", k, got[k].p);
         end
      end
      repeat (4) begin
         send(16'sd32767);
         collect(2, 1'b0);
      end
      checks++;
      if (int'(got[0].p) != 65534 || int'(got[1].p) != 65534) begin
         errors++;
         $display("FAIL sign_pos: preadd=%0d,%0d, required 65534,65534", got[0].p, got[1].p);
      end
   endtask

   task automatic test_timing();
      logic exp_mv[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic exp_rdy[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      sel = 1'b0;
      m_ready = 1'b1;
      do_reset();
      send(16'sd7);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (o_mv !== exp_mv[c] || o_rdy !== exp_rdy[c]) begin
            errors++;
            $display("FAIL timing_T+%0d: m_valid=%b s_ready=%b, required %b %b",
                     c + 1, o_mv, o_rdy, exp_mv[c], exp_rdy[c]);
         end
         if (c == 2) begin
            checks++;
            if (int'(o_p) != 7 || o_idx != 0 || o_last !== 1'b0) begin
               errors++;
               $display("FAIL timing_beat0: (%0d,%0d,%b), required (7,0,0)", o_p, o_idx, o_last);
            end
         end
      end
   endtask

   task automatic test_wrap();
      beat_t e;
      sel = 1'b1;
      do_reset();
      for (int i = 1; i <= 20; i++) begin
         send(DW'(i));
         collect(3, 1'b0);
         for (int k = 0; k < 3; k++) begin
            e = model_beat(k, 5);
            checks++;
            if (int'(got[k].p) != int'(e.p) || got[k].idx != e.idx || got[k].last !== e.last) begin
               errors++;
               $display("FAIL wrap_s%0d_k%0d: (%0d,%0d,%b), required (%0d,%0d,%b)",
                        i, k, got[k].p, got[k].idx, got[k].last, e.p, e.idx, e.last);
            end
         end
      end
      checks++;
      if (int'(got[0].p) != 36 || int'(got[1].p) != 36 || int'(got[2].p) != 18) begin
         errors++;
         $display("FAIL wrap_final: %0d %0d %0d, required 36 36 18", got[0].p, got[1].p, got[2].p);
      end
   endtask

   task automatic test_random_backpressure();
      beat_t e;
      logic signed [DW-1:0] d;
      sel = 1'b1;
      do_reset();
      for (int i = 0; i < 1000; i++) begin
         d = DW'($urandom);
         send(d);
         collect(3, 1'b1);
         for (int k = 0; k < 3; k++) begin
            e = model_beat(k, 5);
            checks++;
            if (int'(got[k].p) != int'(e.p) || got[k].idx != e.idx || got[k].last !== e.last) begin
               errors++;
               $display("FAIL random_s%0d_k%0d: (%0d,%0d,%b), required (%0d,%0d,%b)",
                        i, k, got[k].p, got[k].idx, got[k].last, e.p, e.idx, e.last);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      int n;
      bit stale;
      sel = 1'b0;
      do_reset();
      send(16'sd3);
      repeat (3) @(negedge clk);
      checks++;
      if (o_mv !== 1'b1) begin
         errors++;
         $display("FAIL midreset_inflight: m_valid=%b, required 1", o_mv);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (o_mv !== 1'b0 || o_rdy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_next: m_valid=%b s_ready=%b, required 0 0", o_mv, o_rdy);
      end
      rst_n = 1'b1;
      n = 0;
      stale = 1'b0;
      while (!o_rdy && n < 100) begin
         if (o_mv) stale = 1'b1;
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != 8 || stale) begin
         errors++;
         $display("FAIL midreset_clear: clear cycles=%0d stale_beat=%b, required 8 0", n, stale);
      end
      hist.delete();
      send(16'sd5);
      collect(2, 1'b0);
      checks++;
      if (int'(got[0].p) != 5 || int'(got[1].p) != 0 || got[1].last !== 1'b1) begin
         errors++;
         $display("FAIL midreset_after: %0d %0d last=%b, required 5 0 1", got[0].p, got[1].p, got[1].last);
      end
   endtask

`ifdef SYM_TAP_READER_ANTISYM_EN
   task automatic test_antisym();
      sel = 1'b0;
      antisym = 1'b1;
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         send(DW'(i));
         collect(2, 1'b0);
      end
      checks++;
      if (int'(got[0].p) != 3 || int'(got[1].p) != 1) begin
         errors++;
         $display("FAIL antisym_taps4: %0d %0d, required 3 1", got[0].p, got[1].p);
      end
      sel = 1'b1;
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         send(DW'(i));
         collect(3, 1'b0);
      end
      checks++;
      if (int'(got[0].p) != 4 || int'(got[1].p) != 2 || int'(got[2].p) != 0) begin
         errors++;
         $display("FAIL antisym_taps5: %0d %0d %0d, required 4 2 0", got[0].p, got[1].p, got[2].p);
      end
      antisym = 1'b0;
   endtask
`endif

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b1;
      sel     = 1'b0;
      antisym = 1'b0;
      test_reset();
      test_taps4();
      test_taps5_centre();
      test_sign_ext();
      test_timing();
      test_wrap();
      test_mid_reset();
`ifdef SYM_TAP_READER_ANTISYM_EN
      test_antisym();
`endif
      test_random_backpressure();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
